// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register result countdowns, RAW/WAW
// stall generation, EX/MEM and MEM/WB forward selects, stall counter.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   id_valid               decode holds a valid instruction
//   id_rs_idx              NUM_SRC packed 5-bit source indices
//   id_regWrite, id_rd_idx decode destination write enable / index
//   id_lat                 cycles until result forwardable (0 acts as 1)
//   ex_mem_regWrite/rd_idx EX/MEM writer
//   mem_wb_regWrite/rd_idx MEM/WB writer
//   flush                  discard all in-flight producers
//   stall, issue           decode hold / instruction leaves decode
//   fwd_sel                2-bit forward select per source port
//   stall_count            saturating stalled-cycle counter
module hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NUM_SRC*5-1:0] id_rs_idx,
  input  logic                 id_regWrite,
  input  logic [4:0]           id_rd_idx,
  input  logic [LAT_W-1:0]     id_lat,
  input  logic                 ex_mem_regWrite,
  input  logic [4:0]           ex_mem_rd_idx,
  input  logic                 mem_wb_regWrite,
  input  logic [4:0]           mem_wb_rd_idx,
  input  logic                 flush,
  output logic                 stall,
  output logic                 issue,
  output logic [NUM_SRC*2-1:0] fwd_sel,
  output logic [15:0]          stall_count
);

  logic [LAT_W-1:0] r_cnt [32];
  logic [15:0]      r_stall_count;

  logic [LAT_W-1:0] w_lat_m1;
  logic             w_raw;
  logic             w_waw;
  logic             w_stall;
  logic             w_issue;
  logic             w_load;

  // Countdown value loaded on issue: max(id_lat,1)-1.
  assign w_lat_m1 = (id_lat == '0) ? '0 : id_lat - 1'b1;

  always_comb begin
    w_raw = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs_idx[5*k +: 5] != 5'd0 &&
          r_cnt[id_rs_idx[5*k +: 5]] != '0)
        w_raw = 1'b1;
    end
  end

  // A younger writer may not finish before an older one to the same reg.
  assign w_waw = id_regWrite && (id_rd_idx != 5'd0) &&
                 (r_cnt[id_rd_idx] > w_lat_m1);

  assign w_stall = id_valid & ~flush & (w_raw | w_waw);
  assign w_issue = id_valid & ~w_stall & ~flush;
  assign w_load  = w_issue & id_regWrite & (id_rd_idx != 5'd0);

  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_mem_regWrite && ex_mem_rd_idx != 5'd0 &&
          ex_mem_rd_idx == id_rs_idx[5*k +: 5])
        fwd_sel[2*k +: 2] = 2'b10;
      else if (mem_wb_regWrite && mem_wb_rd_idx != 5'd0 &&
               mem_wb_rd_idx == id_rs_idx[5*k +: 5])
        fwd_sel[2*k +: 2] = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < 32; r++)
        r_cnt[r] <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (w_load && id_rd_idx == 5'(r))
          r_cnt[r] <= w_lat_m1;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_count <= '0;
    else if (w_stall && r_stall_count != 16'hFFFF)
      r_stall_count <= r_stall_count + 16'd1;
  end

  assign stall       = w_stall;
  assign issue       = w_issue;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU chain, multi-cycle,
// WAW, forward priority / x0, flush and reset discard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs_idx;
  logic        id_regWrite;
  logic [4:0]  id_rd_idx;
  logic [2:0]  id_lat;
  logic        ex_mem_regWrite;
  logic [4:0]  ex_mem_rd_idx;
  logic        mem_wb_regWrite;
  logic [4:0]  mem_wb_rd_idx;
  logic        flush;
  logic        stall;
  logic        issue;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_count;

  int n_pass  = 0;
  int n_total = 0;

  hazard_scoreboard #(.NUM_SRC(2), .LAT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_idx(id_rs_idx),
    .id_regWrite(id_regWrite), .id_rd_idx(id_rd_idx),
    .id_lat(id_lat),
    .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd_idx(ex_mem_rd_idx),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd_idx(mem_wb_rd_idx),
    .flush(flush), .stall(stall), .issue(issue),
    .fwd_sel(fwd_sel), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_idx = '0; id_regWrite = 0;
    id_rd_idx = '0; id_lat = '0;
    ex_mem_regWrite = 0; ex_mem_rd_idx = '0;
    mem_wb_regWrite = 0; mem_wb_rd_idx = '0;
    flush = 0;
  endtask

  task automatic issue_wr(input logic [4:0] rd, input logic [2:0] lat);
    id_valid = 1; id_regWrite = 1; id_rd_idx = rd;
    id_lat = lat; id_rs_idx = '0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    rst = 0;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall);
    else n_pass++;
    n_total++;
    if (issue !== 1'b0) $display("FAIL reset_issue got %b want 0", issue);
    else n_pass++;
    n_total++;
    if (fwd_sel !== 4'b0) $display("FAIL reset_fwd got %b want 0000", fwd_sel);
    else n_pass++;
    n_total++;
    if (stall_count !== 16'd0)
      $display("FAIL reset_cnt got %0d want 0", stall_count);
    else n_pass++;
  endtask

  task automatic test_load_use();
    issue_wr(5'd3, 3'd2);
    #1;
    n_total++;
    if (issue !== 1'b1) $display("FAIL lu_issue_ld got %b want 1", issue);
    else n_pass++;
    step();
    id_regWrite = 0; id_rd_idx = '0; id_rs_idx = {5'd0, 5'd3};
    #1;
    n_total++;
    if (stall !== 1'b1 || issue !== 1'b0)
      $display("FAIL lu_stall got s=%b i=%b want s=1 i=0", stall, issue);
    else n_pass++;
    step();
    n_total++;
    if (stall !== 1'b0 || issue !== 1'b1)
      $display("FAIL lu_issue got s=%b i=%b want s=0 i=1", stall, issue);
    else n_pass++;
    step(); idle(); #1;
    n_total++;
    if (stall_count !== 16'd1)
      $display("FAIL lu_count got %0d want 1", stall_count);
    else n_pass++;
  endtask

  task automatic test_alu_chain();
    issue_wr(5'd5, 3'd1);
    step();
    id_regWrite = 0; id_rd_idx = '0; id_rs_idx = {5'd5, 5'd0};
    ex_mem_regWrite = 1; ex_mem_rd_idx = 5'd5;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL alu_stall got %b want 0", stall);
    else n_pass++;
    n_total++;
    if (fwd_sel !== 4'b1000)
      $display("FAIL alu_fwd got %b want 1000", fwd_sel);
    else n_pass++;
    step(); idle();
  endtask

  task automatic test_multicycle();
    int stalls;
    issue_wr(5'd7, 3'd5);
    step();
    id_regWrite = 0; id_rd_idx = '0; id_rs_idx = {5'd0, 5'd7};
    #1;
    stalls = 0;
    for (int i = 0; i < 12 && stall; i++) begin
      stalls++;
      step();
    end
    n_total++;
    if (stalls !== 4) $display("FAIL mc_stalls got %0d want 4", stalls);
    else n_pass++;
    n_total++;
    if (issue !== 1'b1) $display("FAIL mc_issue got %b want 1", issue);
    else n_pass++;
    step();
    issue_wr(5'd7, 3'd5);
    step();
    id_regWrite = 0; id_rd_idx = '0; id_rs_idx = {5'd0, 5'd2};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (stall !== 1'b0 || issue !== 1'b1)
        $display("FAIL mc_indep%0d got s=%b i=%b want s=0 i=1",
                 i, stall, issue);
      else n_pass++;
      step();
    end
    idle(); step();
    n_total++;
    if (stall_count !== 16'd5)
      $display("FAIL mc_count got %0d want 5", stall_count);
    else n_pass++;
  endtask

  task automatic test_waw();
    int stalls;
    issue_wr(5'd9, 3'd6);
    step();
    issue_wr(5'd9, 3'd1);
    #1;
    stalls = 0;
    for (int i = 0; i < 12 && stall; i++) begin
      stalls++;
      step();
    end
    n_total++;
    if (stalls !== 5) $display("FAIL waw_stalls got %0d want 5", stalls);
    else n_pass++;
    n_total++;
    if (issue !== 1'b1) $display("FAIL waw_issue got %b want 1", issue);
    else n_pass++;
    step(); idle(); #1;
    n_total++;
    if (stall_count !== 16'd10)
      $display("FAIL waw_count got %0d want 10", stall_count);
    else n_pass++;
  endtask

  task automatic test_fwd_priority();
    id_valid = 1; id_rs_idx = {5'd0, 5'd8};
    ex_mem_regWrite = 1; ex_mem_rd_idx = 5'd8;
    mem_wb_regWrite = 1; mem_wb_rd_idx = 5'd8;
    #1;
    n_total++;
    if (fwd_sel !== 4'b0010)
      $display("FAIL fwd_prio got %b want 0010", fwd_sel);
    else n_pass++;
    ex_mem_regWrite = 0;
    #1;
    n_total++;
    if (fwd_sel !== 4'b0001)
      $display("FAIL fwd_memwb got %b want 0001", fwd_sel);
    else n_pass++;
    step();
    issue_wr(5'd0, 3'd7);
    step();
    id_regWrite = 0; id_rs_idx = '0;
    ex_mem_regWrite = 1; ex_mem_rd_idx = 5'd0;
    mem_wb_regWrite = 1; mem_wb_rd_idx = 5'd0;
    #1;
    n_total++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0)
      $display("FAIL fwd_x0 got f=%b s=%b want f=0000 s=0", fwd_sel, stall);
    else n_pass++;
    step(); idle();
  endtask

  task automatic test_flush_reset();
    issue_wr(5'd4, 3'd7);
    step();
    id_regWrite = 0; id_rd_idx = '0; id_rs_idx = {5'd0, 5'd4};
    flush = 1;
    #1;
    n_total++;
    if (stall !== 1'b0 || issue !== 1'b0)
      $display("FAIL fl_during got s=%b i=%b want s=0 i=0", stall, issue);
    else n_pass++;
    step();
    flush = 0;
    #1;
    n_total++;
    if (stall !== 1'b0 || issue !== 1'b1)
      $display("FAIL fl_after got s=%b i=%b want s=0 i=1", stall, issue);
    else n_pass++;
    step();
    issue_wr(5'd4, 3'd7);
    step();
    idle(); rst = 1;
    step();
    rst = 0;
    id_valid = 1; id_rs_idx = {5'd0, 5'd4};
    #1;
    n_total++;
    if (stall !== 1'b0 || issue !== 1'b1)
      $display("FAIL rst_after got s=%b i=%b want s=0 i=1", stall, issue);
    else n_pass++;
    n_total++;
    if (stall_count !== 16'd0)
      $display("FAIL rst_count got %0d want 0", stall_count);
    else n_pass++;
    step(); idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_load_use();
    test_alu_chain();
    test_multicycle();
    test_waw();
    test_fwd_priority();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2, number of source-register read ports checked per decoded instruction (1..4).
REQ-002 Parameter LAT_W, default 3, width of latency field and per-register countdown; max latency 2**LAT_W-1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode stage holds a valid instruction.
REQ-006 id_rs_idx  in  NUM_SRC*5  source register indices; port k occupies bits [5k+4:5k].
REQ-007 id_regWrite  in  1  decoded instruction writes id_rd_idx.
REQ-008 id_rd_idx  in  5  destination register index.
REQ-009 id_lat  in  LAT_W  cycles from issue until result is forwardable from EX/MEM (1 = ALU, 2 = load, >2 = multi-cycle); 0 treated as 1.
REQ-010 ex_mem_regWrite  in  1  EX/MEM stage writes a register.
REQ-011 ex_mem_rd_idx  in  5  EX/MEM destination index.
REQ-012 mem_wb_regWrite  in  1  MEM/WB stage writes a register.
REQ-013 mem_wb_rd_idx  in  5  MEM/WB destination index.
REQ-014 flush  in  1  pipeline flush (branch/exception); discards all in-flight producers.
REQ-015 stall  out  1  hold IF/ID, insert bubble into ID/EX.
REQ-016 issue  out  1  instruction leaves decode this cycle.
REQ-017 fwd_sel  out  NUM_SRC*2  forward select per source port k at bits [2k+1:2k].
REQ-018 stall_count  out  16  saturating count of stalled cycles.

Function
REQ-019 Registers 1..31 each hold a LAT_W-bit countdown cnt[r]; register 0 never tracked and never causes a stall or forward.
REQ-020 Each cycle, every nonzero cnt[r] decrements by 1.
REQ-021 On issue=1 with id_regWrite=1 and id_rd_idx!=0, cnt[id_rd_idx] loads max(id_lat,1)-1; this load overrides that register's decrement in the same cycle.
REQ-022 RAW stall: source k is hazardous when id_rs_idx[k]!=0 and cnt[id_rs_idx[k]]!=0.
REQ-023 WAW stall: id_regWrite=1, id_rd_idx!=0 and cnt[id_rd_idx] > max(id_lat,1)-1 (guarantees in-order writeback).
REQ-024 stall = id_valid & ~flush & (any RAW | WAW); combinational from current state and inputs.
REQ-025 issue = id_valid & ~stall & ~flush.
REQ-026 A one-cycle load (id_lat=2) followed by a dependent instruction yields exactly one stall cycle; id_lat=1 yields none.
REQ-027 fwd_sel[k] = 2'b10 when ex_mem_regWrite & ex_mem_rd_idx!=0 & ex_mem_rd_idx==id_rs_idx[k]; else 2'b01 when mem_wb_regWrite & mem_wb_rd_idx!=0 & mem_wb_rd_idx==id_rs_idx[k]; else 2'b00. EX/MEM has priority; fwd_sel is combinational and independent of stall.
REQ-028 flush=1: all cnt[r] cleared on that edge; no issue; stall=0 that cycle.
REQ-029 stall_count increments on each edge with stall=1; holds at 16'hFFFF; not cleared by flush.

Reset
REQ-030 rst=1 on an edge: all cnt[r]=0, stall_count=0; rst overrides issue, decrement and flush.
REQ-031 After reset, with id_valid=0: stall=0, issue=0, fwd_sel=0.
REQ-032 Reset asserted mid-multi-cycle operation discards it; first post-reset instruction reading that register does not stall.

Verification
REQ-033 Load-use: issue rd=3 id_lat=2; next cycle rs1=3 -> stall=1 one cycle, then issue=1; stall_count=1.
REQ-034 ALU chain: issue rd=5 id_lat=1; next cycle rs2=5 -> stall=0; with ex_mem_regWrite=1, ex_mem_rd_idx=5 -> fwd_sel[3:2]=2'b10.
REQ-035 Multi-cycle: issue rd=7 id_lat=5; dependent rs1=7 next cycle -> stall=1 for 4 cycles, issue on 5th; independent rs1=2 never stalls.
REQ-036 WAW: issue rd=9 id_lat=6; next cycle rd=9 id_lat=1 -> stall=1 until cnt[9]=0, then issue.
REQ-037 Forward priority and x0: ex_mem_rd=mem_wb_rd=8, both regWrite=1, rs1=8 -> fwd_sel[1:0]=2'b10; rd=0, rs1=0 -> 2'b00, no stall.
REQ-038 Flush/reset: issue rd=4 id_lat=7; flush next cycle; then rs1=4 -> stall=0; repeat with rst instead -> stall=0, stall_count=0.
